// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared RS232 definitions for the TX and RX paths: FSM state
//                encoding, frame geometry, line levels and a parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_bps_module.sv
`default_nettype none
// ============================================================================
//  Module      : tx_bps_module
//  Description : Baud-rate counter. Counts 0..BAUD_DIV-1 while not cleared and
//                raises BPS_Tick for one cycle when the count reaches
//                TICK_POINT (end of bit by default, mid-bit for the RX path).
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_bps_module #(
    parameter int BAUD_DIV   = 434,
    parameter int TICK_POINT = BAUD_DIV - 1
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic BPS_Clear,
    output logic BPS_Tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] c_TICK_AT  = CNT_W'(TICK_POINT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (BPS_Clear || (r_cnt == c_CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Suppressed while cleared so an idle transmitter never sees a stray tick.
    assign BPS_Tick = !BPS_Clear && (r_cnt == c_TICK_AT);

endmodule

`default_nettype wire

// File: rtl/tx_module.sv
`default_nettype none
// ============================================================================
//  Module      : tx_module
//  Description : UART transmitter, 8 data bits LSB first, one stop bit, idle
//                high. Optional even-parity bit when TX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_module
    import rs232_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 TX_En_Sig,
    input  logic [DATA_BITS-1:0] TX_Data,
    output logic                 TX_Pin_Out,
    output logic                 TX_Busy,
    output logic                 TX_Done_Sig
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 w_bps_clear;
    logic                 w_tick;
`ifdef TX_PARITY_EN
    logic                 r_parity;
`endif

    // Baud counter sits at zero in IDLE, so every frame starts phase-aligned.
    assign w_bps_clear = (r_state == TX_IDLE);

    tx_bps_module #(
        .BAUD_DIV (BAUD_DIV)
    ) u_bps (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .BPS_Clear (w_bps_clear),
        .BPS_Tick  (w_tick)
    );

    // The line register is loaded with the level of the state being entered,
    // keeping TX_Pin_Out glitch-free and aligned to the bit boundaries.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= TX_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            TX_Pin_Out  <= LINE_IDLE;
            TX_Busy     <= 1'b0;
            TX_Done_Sig <= 1'b0;
`ifdef TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            TX_Done_Sig <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    TX_Pin_Out <= LINE_IDLE;
                    TX_Busy    <= 1'b0;
                    if (TX_En_Sig) begin
                        r_shift    <= TX_Data;
                        r_bit_cnt  <= '0;
`ifdef TX_PARITY_EN
                        r_parity   <= even_parity(TX_Data);
`endif
                        TX_Pin_Out <= LINE_START;
                        TX_Busy    <= 1'b1;
                        r_state    <= TX_START;
                    end
                end

                TX_START: begin
                    if (w_tick) begin
                        TX_Pin_Out <= r_shift[0];
                        r_state    <= TX_DATA;
                    end
                end

                TX_DATA: begin
                    if (w_tick) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_LAST_BIT) begin
`ifdef TX_PARITY_EN
                            TX_Pin_Out <= r_parity;
                            r_state    <= TX_PARITY;
`else
                            TX_Pin_Out <= LINE_IDLE;
                            r_state    <= TX_STOP;
`endif
                        end else begin
                            TX_Pin_Out <= r_shift[1];
                        end
                    end
                end

`ifdef TX_PARITY_EN
                TX_PARITY: begin
                    if (w_tick) begin
                        TX_Pin_Out <= LINE_IDLE;
                        r_state    <= TX_STOP;
                    end
                end
`endif

                TX_STOP: begin
                    if (w_tick) begin
                        TX_Pin_Out  <= LINE_IDLE;
                        TX_Busy     <= 1'b0;
                        TX_Done_Sig <= 1'b1;
                        r_state     <= TX_IDLE;
                    end
                end

                default: begin
                    TX_Pin_Out <= LINE_IDLE;
                    TX_Busy    <= 1'b0;
                    r_state    <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tx_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_module
//  Description : Self-checking bench for tx_module at BAUD_DIV = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_module;

    localparam int BAUD_DIV = 4;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * BAUD_DIV;

    logic       CLK       = 1'b0;
    logic       RSTn      = 1'b0;
    logic       TX_En_Sig = 1'b0;
    logic [7:0] TX_Data   = 8'h00;
    logic       TX_Pin_Out;
    logic       TX_Busy;
    logic       TX_Done_Sig;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    tx_module #(
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .TX_En_Sig   (TX_En_Sig),
        .TX_Data     (TX_Data),
        .TX_Pin_Out  (TX_Pin_Out),
        .TX_Busy     (TX_Busy),
        .TX_Done_Sig (TX_Done_Sig)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected line levels of one frame, one entry per bit period.
    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Present a request in the current cycle; returns at t=0 of the frame.
    task automatic request(input logic [7:0] d, input bit hold);
        TX_Data   = d;
        TX_En_Sig = 1'b1;
        push_frame(d);
        step();
        if (!hold) TX_En_Sig = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        TX_En_Sig = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b100) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got line/busy/done=%b expected 100",
                         i, {TX_Pin_Out, TX_Busy, TX_Done_Sig});
            end
        end
        RSTn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b100) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got line/busy/done=%b expected 100",
                         i, {TX_Pin_Out, TX_Busy, TX_Done_Sig});
            end
        end
    endtask

    task automatic test_single_byte(input logic [7:0] d);
        logic e;
        e = 1'b1;
        request(d, 1'b0);
        for (int t = 0; t < FRAME_LEN; t++) begin
            if (t % BAUD_DIV == 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL single_queue t=%0d got empty scoreboard expected a bit", t);
                end else begin
                    e = exp_q.pop_front();
                end
            end
            checks++;
            if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== {e, 2'b10}) begin
                errors++;
                $display("FAIL single_%02h t=%0d got line/busy/done=%b expected %b",
                         d, t, {TX_Pin_Out, TX_Busy, TX_Done_Sig}, {e, 2'b10});
            end
            step();
        end
        checks++;
        if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b101) begin
            errors++;
            $display("FAIL single_done_%02h t=%0d got line/busy/done=%b expected 101",
                     d, FRAME_LEN, {TX_Pin_Out, TX_Busy, TX_Done_Sig});
        end
        step();
        checks++;
        if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b100) begin
            errors++;
            $display("FAIL single_after_%02h got line/busy/done=%b expected 100",
                     d, {TX_Pin_Out, TX_Busy, TX_Done_Sig});
        end
        step();
    endtask

    task automatic test_busy_ignore();
        logic e;
        int   done_cnt;
        e = 1'b1;
        done_cnt = 0;
        request(8'h55, 1'b0);
        for (int t = 0; t < FRAME_LEN + 8; t++) begin
            if (t < FRAME_LEN) begin
                if (t % BAUD_DIV == 0 && exp_q.size() != 0) e = exp_q.pop_front();
                checks++;
                if (TX_Pin_Out !== e) begin
                    errors++;
                    $display("FAIL busy_line t=%0d got %b expected %b", t, TX_Pin_Out, e);
                end
            end
            if (TX_Done_Sig === 1'b1) done_cnt++;
            if (t == 12) begin
                TX_En_Sig = 1'b1;
                TX_Data   = 8'hA3;
            end
            if (t == 20) TX_En_Sig = 1'b0;
            step();
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL busy_done_count got %0d expected 1", done_cnt);
        end
        checks++;
        if (TX_Busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_end got busy=%b queue=%0d expected busy=0 queue=0",
                     TX_Busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        e = 1'b1;
        request(8'h00, 1'b1);
        for (int t = 0; t < FRAME_LEN; t++) begin
            if (t % BAUD_DIV == 0 && exp_q.size() != 0) e = exp_q.pop_front();
            checks++;
            if ({TX_Pin_Out, TX_Busy} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL b2b_first t=%0d got line/busy=%b expected %b",
                         t, {TX_Pin_Out, TX_Busy}, {e, 1'b1});
            end
            step();
        end
        checks++;
        if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_done got line/busy/done=%b expected 101",
                     {TX_Pin_Out, TX_Busy, TX_Done_Sig});
        end
        TX_Data = 8'hFF;
        push_frame(8'hFF);
        step();
        TX_En_Sig = 1'b0;
        for (int t = 0; t < FRAME_LEN; t++) begin
            if (t % BAUD_DIV == 0 && exp_q.size() != 0) e = exp_q.pop_front();
            checks++;
            if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== {e, 2'b10}) begin
                errors++;
                $display("FAIL b2b_second t=%0d got line/busy/done=%b expected %b",
                         t, {TX_Pin_Out, TX_Busy, TX_Done_Sig}, {e, 2'b10});
            end
            step();
        end
        checks++;
        if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b101 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_second_done got line/busy/done=%b queue=%0d expected 101 queue=0",
                     {TX_Pin_Out, TX_Busy, TX_Done_Sig}, exp_q.size());
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        request(8'hF0, 1'b0);
        for (int t = 0; t < 17; t++) step();
        checks++;
        if ({TX_Pin_Out, TX_Busy} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_before got line/busy=%b expected 01", {TX_Pin_Out, TX_Busy});
        end
        #2;
        RSTn = 1'b0;
        #1;
        checks++;
        if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_async got line/busy/done=%b expected 100",
                     {TX_Pin_Out, TX_Busy, TX_Done_Sig});
        end
        exp_q.delete();
        step();
        step();
        RSTn = 1'b1;
        for (int t = 0; t < 2 * FRAME_LEN; t++) begin
            step();
            checks++;
            if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b100) begin
                errors++;
                $display("FAIL midrst_after cyc=%0d got line/busy/done=%b expected 100",
                         t, {TX_Pin_Out, TX_Busy, TX_Done_Sig});
            end
        end
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] line_bits;
        line_bits = 11'b11_0000_0111_0;
        request(8'h07, 1'b0);
        exp_q.delete();
        for (int t = 0; t < 44; t++) begin
            checks++;
            if (TX_Pin_Out !== line_bits[t / 4] || TX_Done_Sig !== 1'b0) begin
                errors++;
                $display("FAIL parity_line t=%0d got line/done=%b%b expected %b0",
                         t, TX_Pin_Out, TX_Done_Sig, line_bits[t / 4]);
            end
            step();
        end
        checks++;
        if ({TX_Pin_Out, TX_Busy, TX_Done_Sig} !== 3'b101) begin
            errors++;
            $display("FAIL parity_done t=44 got line/busy/done=%b expected 101",
                     {TX_Pin_Out, TX_Busy, TX_Done_Sig});
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte(8'h55);
        test_single_byte(8'h07);
        test_single_byte(8'hA3);
        test_busy_ignore();
        step();
        test_back_to_back();
        step();
        test_reset_mid_frame();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
